// File: rtl/full_adder_unit_if.sv
// Operand/result bundle for full_adder_unit: the producer drives the operands,
// and the adder returns the sum, the carry and the result-valid flag.
interface full_adder_unit_if #(
    parameter int WIDTH = 1
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic [WIDTH-1:0] s;
    logic             c_out;
    logic             out_valid;

    modport master (
        output in_valid, a, b, c_in,
        input  s, c_out, out_valid
    );

    modport slave (
        input  in_valid, a, b, c_in,
        output s, c_out, out_valid
    );
endinterface

// File: rtl/full_adder_unit.sv
// Ripple-carry adder built from 1-bit full-adder cells: {c_out,s} = a + b + c_in.
// With REG_OUT=1 the result is registered (latency 1); with REG_OUT=0 it is combinational.
module full_adder_unit #(
    parameter int WIDTH   = 1,
    parameter int REG_OUT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    full_adder_unit_if.slave  bus
);

    // Chain of full-adder cells; the returned MSB is the carry out of the last cell.
    function automatic logic [WIDTH:0] ripple_add(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic             cin
    );
        logic [WIDTH:0]   c;
        logic [WIDTH-1:0] sm;
        c    = '0;
        sm   = '0;
        c[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            sm[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1]  = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
        return {c[WIDTH], sm};
    endfunction

    logic [WIDTH:0] sum_full;

    assign sum_full = ripple_add(bus.a, bus.b, bus.c_in);

    if (REG_OUT != 0) begin : g_reg
        logic [WIDTH-1:0] s_d, s_q;
        logic             c_out_d, c_out_q;
        logic             out_valid_d, out_valid_q;

        // Operands are only looked at when valid, so X on idle inputs never reaches the held result.
        always_comb begin
            s_d         = s_q;
            c_out_d     = c_out_q;
            out_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s_d     = sum_full[WIDTH-1:0];
                c_out_d = sum_full[WIDTH];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_q         <= '0;
                c_out_q     <= 1'b0;
                out_valid_q <= 1'b0;
            end else begin
                s_q         <= s_d;
                c_out_q     <= c_out_d;
                out_valid_q <= out_valid_d;
            end
        end

        assign bus.s         = s_q;
        assign bus.c_out     = c_out_q;
        assign bus.out_valid = out_valid_q;
    end else begin : g_comb
        // Clock and reset have no role in the combinational build.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;

        assign bus.s         = sum_full[WIDTH-1:0];
        assign bus.c_out     = sum_full[WIDTH];
        assign bus.out_valid = bus.in_valid;
    end

endmodule

// File: tb/tb_full_adder_unit.sv
// Randomized self-checking bench for full_adder_unit: registered 1-bit and 8-bit
// builds plus a combinational 1-bit build, checked against a plain-arithmetic model.
module tb_full_adder_unit;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    full_adder_unit_if #(.WIDTH(1)) w1_if ();
    full_adder_unit_if #(.WIDTH(8)) w8_if ();
    full_adder_unit_if #(.WIDTH(1)) c1_if ();

    full_adder_unit #(.WIDTH(1), .REG_OUT(1)) u_w1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (w1_if.slave)
    );

    full_adder_unit #(.WIDTH(8), .REG_OUT(1)) u_w8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (w8_if.slave)
    );

    full_adder_unit #(.WIDTH(1), .REG_OUT(0)) u_c1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (c1_if.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference state for the 8-bit registered adder: what it should be showing now.
    logic [7:0] m_s;
    logic       m_c;
    logic       m_v;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock of the 8-bit adder: compare against the model, apply new operands,
    // then advance the model across the coming edge.
    task automatic w8_cycle(input logic vld, input logic [7:0] va, input logic [7:0] vb,
                            input logic vc);
        logic [8:0] total;
        @(negedge clk);
        check_eq("w8_s",     {8'h00, w8_if.s},  {8'h00, m_s});
        check_eq("w8_c_out", {15'h0, w8_if.c_out}, {15'h0, m_c});
        check_eq("w8_valid", {15'h0, w8_if.out_valid}, {15'h0, m_v});
        w8_if.in_valid = vld;
        w8_if.a        = va;
        w8_if.b        = vb;
        w8_if.c_in     = vc;
        if (vld) begin
            total = {1'b0, va} + {1'b0, vb} + {8'h00, vc};
            m_s   = total[7:0];
            m_c   = total[8];
        end
        m_v = vld;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] exp2;
        logic       pa, pb, pc;
        logic [1:0] prev;

        w1_if.in_valid = 1'b0; w1_if.a = '0; w1_if.b = '0; w1_if.c_in = 1'b0;
        w8_if.in_valid = 1'b0; w8_if.a = '0; w8_if.b = '0; w8_if.c_in = 1'b0;
        c1_if.in_valid = 1'b0; c1_if.a = '0; c1_if.b = '0; c1_if.c_in = 1'b0;
        m_s = 8'h00; m_c = 1'b0; m_v = 1'b0;
        prev = 2'b00;

        // Combinational build: truth table with in_valid both low and high, 1 ns after each change.
        for (int v = 0; v < 8; v++) begin
            for (int vl = 0; vl < 2; vl++) begin
                pa = v[2]; pb = v[1]; pc = v[0];
                c1_if.a = pa; c1_if.b = pb; c1_if.c_in = pc; c1_if.in_valid = vl[0];
                #1;
                exp2 = {1'b0, pa} + {1'b0, pb} + {1'b0, pc};
                check_eq("comb_s",     {15'h0, c1_if.s},         {15'h0, exp2[0]});
                check_eq("comb_c_out", {15'h0, c1_if.c_out},     {15'h0, exp2[1]});
                check_eq("comb_valid", {15'h0, c1_if.out_valid}, {15'h0, vl[0]});
            end
        end

        // Reset state with reset held from time zero.
        #1;
        check_eq("rst_w1_s",     {15'h0, w1_if.s},         16'h0);
        check_eq("rst_w1_c_out", {15'h0, w1_if.c_out},     16'h0);
        check_eq("rst_w1_valid", {15'h0, w1_if.out_valid}, 16'h0);
        check_eq("rst_w8_s",     {8'h0, w8_if.s},          16'h0);
        check_eq("rst_w8_valid", {15'h0, w8_if.out_valid}, 16'h0);

        @(negedge clk);
        rst_n = 1'b1;

        // Exhaustive 1-bit registered truth table, one vector per clock.
        for (int v = 0; v < 9; v++) begin
            @(negedge clk);
            if (v > 0) begin
                check_eq("tt_s",     {15'h0, w1_if.s},         {15'h0, prev[0]});
                check_eq("tt_c_out", {15'h0, w1_if.c_out},     {15'h0, prev[1]});
                check_eq("tt_valid", {15'h0, w1_if.out_valid}, 16'h1);
            end
            if (v < 8) begin
                pa = v[2]; pb = v[1]; pc = v[0];
                w1_if.a = pa; w1_if.b = pb; w1_if.c_in = pc; w1_if.in_valid = 1'b1;
                prev = {1'b0, pa} + {1'b0, pb} + {1'b0, pc};
            end
        end

        // Asynchronous reset between edges with valid operands 1,1,1 applied.
        w1_if.a = 1'b1; w1_if.b = 1'b1; w1_if.c_in = 1'b1; w1_if.in_valid = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_s",     {15'h0, w1_if.s},         16'h0);
        check_eq("arst_c_out", {15'h0, w1_if.c_out},     16'h0);
        check_eq("arst_valid", {15'h0, w1_if.out_valid}, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rel_s",     {15'h0, w1_if.s},         16'h1);
        check_eq("rel_c_out", {15'h0, w1_if.c_out},     16'h1);
        check_eq("rel_valid", {15'h0, w1_if.out_valid}, 16'h1);

        // Hold: idle cycles keep the last result, even with X operands.
        w1_if.a = 1'b1; w1_if.b = 1'b0; w1_if.c_in = 1'b0; w1_if.in_valid = 1'b1;
        @(negedge clk);
        check_eq("hold_load_s",     {15'h0, w1_if.s},         16'h1);
        check_eq("hold_load_c_out", {15'h0, w1_if.c_out},     16'h0);
        check_eq("hold_load_valid", {15'h0, w1_if.out_valid}, 16'h1);
        w1_if.in_valid = 1'b0; w1_if.a = 1'b1; w1_if.b = 1'b1;
        @(negedge clk);
        check_eq("hold_s",     {15'h0, w1_if.s},         16'h1);
        check_eq("hold_c_out", {15'h0, w1_if.c_out},     16'h0);
        check_eq("hold_valid", {15'h0, w1_if.out_valid}, 16'h0);
        w1_if.a = 1'bx; w1_if.b = 1'bx; w1_if.c_in = 1'bx;
        @(negedge clk);
        check_eq("hold_x_s",     {15'h0, w1_if.s},     16'h1);
        check_eq("hold_x_c_out", {15'h0, w1_if.c_out}, 16'h0);
        w1_if.in_valid = 1'b0; w1_if.a = 1'b0; w1_if.b = 1'b0; w1_if.c_in = 1'b0;

        // 8-bit carry chain corners, then random traffic with occasional idle cycles.
        w8_cycle(1'b1, 8'hFF, 8'h00, 1'b1);
        w8_cycle(1'b1, 8'h5A, 8'hA5, 1'b0);
        w8_cycle(1'b1, 8'hFF, 8'hFF, 1'b1);
        w8_cycle(1'b0, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 1250; i++) begin
            w8_cycle($urandom_range(0, 4) != 0, 8'($urandom), 8'($urandom), 1'($urandom));
        end
        w8_cycle(1'b0, 8'hxx, 8'hxx, 1'bx);
        w8_cycle(1'b0, 8'h00, 8'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
